// File: rtl/tensor_core_gemm_pipe.sv
// 4x4 FP16 GEMM tile engine: D = addend + A*B, computed by a bank of tensor_core_mma
// dot-product units that are time-multiplexed over the row groups of the tile.

module tensor_core_mma (
  input  logic [0:3][15:0] a,
  input  logic [0:3][15:0] b,
  input  logic [15:0]      c,
  output logic [15:0]      d
);
  // Products and addend are summed exactly in a wide fixed-point accumulator
  // (LSB = 2^-48), then rounded once to FP16 with round-to-nearest-even.
  // Inf/NaN encodings are not special-cased; overflow saturates to infinity.
  logic [83:0] acc;
  logic [83:0] term;
  logic [82:0] mag;
  logic [21:0] prod;
  logic [6:0]  lead;
  logic [6:0]  shift;
  logic [10:0] mant;
  logic        neg;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [16:0] packed_res;

  function automatic logic [21:0] sig(input logic [14:0] x);
    return {11'd0, (x[14:10] != 5'd0), x[9:0]};
  endfunction

  function automatic logic [6:0] ex(input logic [14:0] x);
    return (x[14:10] == 5'd0) ? 7'd1 : {2'd0, x[14:10]};
  endfunction

  always_comb begin
    term = {62'd0, sig(c[14:0])} << (ex(c[14:0]) + 7'd23);
    acc  = c[15] ? (84'd0 - term) : term;
    for (int k = 0; k < 4; k++) begin
      prod = sig(a[k][14:0]) * sig(b[k][14:0]);
      term = {62'd0, prod} << (ex(a[k][14:0]) + ex(b[k][14:0]) - 7'd2);
      acc  = (a[k][15] ^ b[k][15]) ? (acc - term) : (acc + term);
    end
    neg  = acc[83];
    mag  = 83'(neg ? (84'd0 - acc) : acc);
    lead = 7'd0;
    for (int i = 0; i < 83; i++) begin
      if (mag[i]) lead = 7'(i);
    end
    // Results below 2^-14 keep the fixed subnormal quantum (bit 24 = 2^-24).
    shift      = (lead >= 7'd34) ? (lead - 7'd10) : 7'd24;
    mant       = 11'(mag >> shift);
    guard      = mag[shift - 7'd1];
    sticky     = |(mag & ((83'd1 << (shift - 7'd1)) - 83'd1));
    inc        = guard & (sticky | mant[0]);
    packed_res = {(mant[10] ? (shift - 7'd23) : 7'd0), mant[9:0]} + {16'd0, inc};
    d          = (packed_res[16:10] >= 7'd31) ? {neg, 15'h7C00} : {neg, packed_res[14:0]};
  end
endmodule

module tensor_core_gemm_pipe #(
  parameter int DWIDTH       = 16,
  parameter int ROWS_PER_CYC = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [0:3][0:3][DWIDTH-1:0]  A_in,
  input  logic [0:3][0:3][DWIDTH-1:0]  B_in,
  input  logic [0:3][0:3][DWIDTH-1:0]  C_in,
  input  logic                         acc_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [0:3][0:3][DWIDTH-1:0]  C_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);
  if (!(ROWS_PER_CYC == 1 || ROWS_PER_CYC == 2 || ROWS_PER_CYC == 4)) begin : g_bad_rows
    $error("tensor_core_gemm_pipe: ROWS_PER_CYC must be 1, 2 or 4");
  end
  if (DWIDTH != 16) begin : g_bad_width
    $error("tensor_core_gemm_pipe: tensor_core_mma supports only DWIDTH = 16");
  end

  localparam logic [1:0] STEP = 2'(ROWS_PER_CYC % 4);
  localparam logic [1:0] LAST = 2'(4 - ROWS_PER_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                                   state;
  logic [1:0]                               row_cnt;
  logic [0:3][0:3][DWIDTH-1:0]              a_reg;
  logic [0:3][0:3][DWIDTH-1:0]              bt_reg;
  logic [0:3][0:3][DWIDTH-1:0]              add_reg;
  logic [0:3][0:3][DWIDTH-1:0]              stage;
  logic [0:3][0:3][DWIDTH-1:0]              next_res;
  logic [0:ROWS_PER_CYC-1][0:3][DWIDTH-1:0] grp_out;
  logic                                     accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  for (genvar g = 0; g < ROWS_PER_CYC; g++) begin : g_row
    logic [1:0] row;
    assign row = row_cnt + 2'(g);
    for (genvar c = 0; c < 4; c++) begin : g_col
      tensor_core_mma u_mma (
        .a (a_reg[row]),
        .b (bt_reg[c]),
        .c (add_reg[row][c]),
        .d (grp_out[g][c])
      );
    end
  end

  // Rows are collected in a staging copy so C_out only ever shows whole tiles.
  always_comb begin
    next_res = stage;
    for (int g = 0; g < ROWS_PER_CYC; g++) begin
      next_res[row_cnt + 2'(g)] = grp_out[g];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_cnt   <= 2'd0;
      a_reg     <= '0;
      bt_reg    <= '0;
      add_reg   <= '0;
      stage     <= '0;
      C_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // C_out doubles as the accumulator; on a handoff edge it still holds the outgoing tile.
      a_reg   <= A_in;
      add_reg <= acc_en ? C_out : C_in;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          bt_reg[c][r] <= B_in[r][c];
        end
      end
      row_cnt   <= 2'd0;
      state     <= BUSY;
      busy      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          stage   <= next_res;
          row_cnt <= row_cnt + STEP;
          if (row_cnt == LAST) begin
            C_out     <= next_res;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
